// File: rtl/fill_sweep_scheduler_pkg.sv
// Shared types and frame constants for the fill sweep scheduler and its
// pixel_bram neighbours.
package fill_sweep_scheduler_pkg;

    localparam int          DEFAULT_FRAME_WIDTH  = 512;
    localparam int          DEFAULT_FRAME_HEIGHT = 384;
    localparam int          DEFAULT_FILL_LAT     = 3;
    localparam logic [15:0] DEFAULT_CLEAR_COLOR  = 16'h0000;
    localparam int          PBRAM_ADDR_BITS      = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SWEEP = 2'd2,
        DRAIN = 2'd3
    } sweep_state_t;

    // Linear pixel address y*width + x, truncated to the BRAM address width.
    function automatic logic [PBRAM_ADDR_BITS-1:0] pix_addr(
        input logic [15:0] x,
        input logic [15:0] y,
        input int          width
    );
        logic [31:0] full;
        full = 32'(y) * 32'(width) + 32'(x);
        return full[PBRAM_ADDR_BITS-1:0];
    endfunction

endpackage

// File: rtl/fill_sweep_scheduler_pipe.sv
// Fixed-length register delay line with asynchronous active-low reset;
// carries {valid, addr} alongside the fill unit latency.
module fill_sweep_scheduler_pipe
    import fill_sweep_scheduler_pkg::*;
#(
    parameter int WIDTH  = PBRAM_ADDR_BITS + 1,
    parameter int LENGTH = DEFAULT_FILL_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_tap [LENGTH+1];

    assign w_tap[0] = i_data;

    for (genvar gi = 0; gi < LENGTH; gi++) begin : g_stage
        logic [WIDTH-1:0] r_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else begin
                r_q <= w_tap[gi];
            end
        end

        assign w_tap[gi+1] = r_q;
    end

    assign o_data = w_tap[LENGTH];

endmodule

// File: rtl/fill_sweep_scheduler.sv
// Sequences clear / triangle-fill passes and drives pixel_bram port A.
// Optional feature macro: SWEEP_BBOX_EN (sweep only the clamped triangle bbox).
module fill_sweep_scheduler
    import fill_sweep_scheduler_pkg::*;
#(
    parameter int          FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
    parameter int          FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
    parameter int          FILL_LAT     = DEFAULT_FILL_LAT,
    parameter logic [15:0] CLEAR_COLOR  = DEFAULT_CLEAR_COLOR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_req,
    output logic                       clear_ack,
    input  logic                       tri_valid,
    output logic                       tri_ready,
    input  logic [15:0]                tri_col,
`ifdef SWEEP_BBOX_EN
    input  logic [15:0]                bbox_x0,
    input  logic [15:0]                bbox_x1,
    input  logic [15:0]                bbox_y0,
    input  logic [15:0]                bbox_y1,
`endif
    output logic [15:0]                sx,
    output logic [15:0]                sy,
    input  logic                       is_within,
    output logic                       we,
    output logic [PBRAM_ADDR_BITS-1:0] waddr,
    output logic [15:0]                wdata,
    output logic                       busy,
    output logic                       done
);

    localparam logic [15:0] X_LAST = 16'(FRAME_WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(FRAME_HEIGHT - 1);
    localparam logic [PBRAM_ADDR_BITS-1:0] ADDR_LAST =
        PBRAM_ADDR_BITS'(FRAME_WIDTH * FRAME_HEIGHT - 1);
    localparam int DRAIN_W = (FILL_LAT > 1) ? $clog2(FILL_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(FILL_LAT - 1);

    sweep_state_t               r_state;
    logic [15:0]                r_x;
    logic [15:0]                r_y;
    logic [PBRAM_ADDR_BITS-1:0] r_addr;
    logic                       r_issue_valid;
    logic                       r_clear_we;
    logic                       r_clear_ack;
    logic                       r_done;
    logic                       r_ready_idle;
    logic [15:0]                r_col;
    logic [15:0]                r_x_min;
    logic [15:0]                r_x_max;
    logic [15:0]                r_y_min;
    logic [15:0]                r_y_max;
    logic [DRAIN_W-1:0]         r_drain_left;

    logic [15:0]                w_x_min;
    logic [15:0]                w_x_max;
    logic [15:0]                w_y_min;
    logic [15:0]                w_y_max;
    logic                       w_box_empty;
    logic                       w_tri_fire;
    logic                       w_sweep_last;
    logic [15:0]                w_nx;
    logic [15:0]                w_ny;
    logic [15:0]                w_clr_x;
    logic [15:0]                w_clr_y;
    logic [PBRAM_ADDR_BITS-1:0] w_addr_inc;
    logic [PBRAM_ADDR_BITS:0]   w_pipe_in;
    logic [PBRAM_ADDR_BITS:0]   w_pipe_out;

`ifdef SWEEP_BBOX_EN
    always_comb begin
        w_x_min     = (bbox_x0 > X_LAST) ? X_LAST : bbox_x0;
        w_x_max     = (bbox_x1 > X_LAST) ? X_LAST : bbox_x1;
        w_y_min     = (bbox_y0 > Y_LAST) ? Y_LAST : bbox_y0;
        w_y_max     = (bbox_y1 > Y_LAST) ? Y_LAST : bbox_y1;
        w_box_empty = (w_x_min > w_x_max) || (w_y_min > w_y_max);
    end
`else
    assign w_x_min     = '0;
    assign w_x_max     = X_LAST;
    assign w_y_min     = '0;
    assign w_y_max     = Y_LAST;
    assign w_box_empty = 1'b0;
`endif

    assign tri_ready    = r_ready_idle & ~clear_req;
    assign w_tri_fire   = tri_valid & tri_ready;
    assign w_sweep_last = (r_x == r_x_max) && (r_y == r_y_max);
    assign w_nx         = (r_x == r_x_max) ? r_x_min : r_x + 16'd1;
    assign w_ny         = (r_x == r_x_max) ? r_y + 16'd1 : r_y;
    assign w_clr_x      = (r_x == X_LAST) ? 16'd0 : r_x + 16'd1;
    assign w_clr_y      = (r_x == X_LAST) ? r_y + 16'd1 : r_y;
    assign w_addr_inc   = r_addr + 1'b1;

    // Addresses ride alongside the fill unit so the write lands on the pixel it judged.
    assign w_pipe_in = {r_issue_valid, (r_issue_valid ? r_addr : '0)};

    fill_sweep_scheduler_pipe #(
        .WIDTH  (PBRAM_ADDR_BITS + 1),
        .LENGTH (FILL_LAT)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_pipe_in),
        .o_data (w_pipe_out)
    );

    assign sx        = r_x;
    assign sy        = r_y;
    assign we        = r_clear_we | (w_pipe_out[PBRAM_ADDR_BITS] & is_within);
    assign waddr     = r_clear_we ? r_addr : w_pipe_out[PBRAM_ADDR_BITS-1:0];
    assign wdata     = r_clear_we ? CLEAR_COLOR : r_col;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign clear_ack = r_clear_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_addr        <= '0;
            r_issue_valid <= 1'b0;
            r_clear_we    <= 1'b0;
            r_clear_ack   <= 1'b0;
            r_done        <= 1'b0;
            r_ready_idle  <= 1'b0;
            r_col         <= '0;
            r_x_min       <= '0;
            r_x_max       <= '0;
            r_y_min       <= '0;
            r_y_max       <= '0;
            r_drain_left  <= '0;
        end else begin
            r_clear_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready_idle <= 1'b1;
                    if (clear_req) begin
                        r_state      <= CLEAR;
                        r_ready_idle <= 1'b0;
                        r_clear_ack  <= 1'b1;
                        r_clear_we   <= 1'b1;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_addr       <= '0;
                        r_done       <= (ADDR_LAST == '0);
                    end else if (w_tri_fire) begin
                        r_ready_idle <= 1'b0;
                        r_col        <= tri_col;
                        r_x_min      <= w_x_min;
                        r_x_max      <= w_x_max;
                        r_y_min      <= w_y_min;
                        r_y_max      <= w_y_max;
                        if (w_box_empty) begin
                            r_state      <= DRAIN;
                            r_drain_left <= DRAIN_INIT;
                            r_done       <= (FILL_LAT == 1);
                        end else begin
                            r_state       <= SWEEP;
                            r_x           <= w_x_min;
                            r_y           <= w_y_min;
                            r_addr        <= pix_addr(w_x_min, w_y_min, FRAME_WIDTH);
                            r_issue_valid <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (r_done) begin
                        r_state      <= IDLE;
                        r_clear_we   <= 1'b0;
                        r_done       <= 1'b0;
                        r_ready_idle <= 1'b1;
                    end else begin
                        r_x    <= w_clr_x;
                        r_y    <= w_clr_y;
                        r_addr <= w_addr_inc;
                        r_done <= (w_addr_inc == ADDR_LAST);
                    end
                end
                SWEEP: begin
                    if (w_sweep_last) begin
                        r_state       <= DRAIN;
                        r_issue_valid <= 1'b0;
                        r_drain_left  <= DRAIN_INIT;
                        r_done        <= (FILL_LAT == 1);
                    end else begin
                        r_x    <= w_nx;
                        r_y    <= w_ny;
                        r_addr <= pix_addr(w_nx, w_ny, FRAME_WIDTH);
                    end
                end
                DRAIN: begin
                    // done lines up with the last coordinate leaving the delay line.
                    if (r_drain_left == '0) begin
                        r_state      <= IDLE;
                        r_done       <= 1'b0;
                        r_ready_idle <= 1'b1;
                    end else begin
                        r_drain_left <= r_drain_left - 1'b1;
                        r_done       <= (r_drain_left == DRAIN_W'(1));
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fill_sweep_scheduler.sv
// Scoreboard bench for fill_sweep_scheduler on an 8x4 frame with a stub fill
// unit (fixed mask, 3-cycle latency); bbox case runs when SWEEP_BBOX_EN is set.
`timescale 1ns/1ps
module tb_fill_sweep_scheduler;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        clear_ack;
    logic        tri_valid = 1'b0;
    logic        tri_ready;
    logic [15:0] tri_col = 16'h0;
    logic [15:0] sx, sy;
    logic        is_within;
    logic        we;
    logic [17:0] waddr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
`ifdef SWEEP_BBOX_EN
    logic [15:0] bbox_x0 = 16'd0;
    logic [15:0] bbox_x1 = 16'd7;
    logic [15:0] bbox_y0 = 16'd0;
    logic [15:0] bbox_y1 = 16'd3;
`endif

    fill_sweep_scheduler #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H),
        .FILL_LAT     (LAT),
        .CLEAR_COLOR  (16'h0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .clear_ack (clear_ack),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .tri_col   (tri_col),
`ifdef SWEEP_BBOX_EN
        .bbox_x0   (bbox_x0),
        .bbox_x1   (bbox_x1),
        .bbox_y0   (bbox_y0),
        .bbox_y1   (bbox_y1),
`endif
        .sx        (sx),
        .sy        (sy),
        .is_within (is_within),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub fill unit: mask of the coordinate presented LAT cycles ago.
    int mask_mode = 0;
    logic [15:0] d_x [LAT];
    logic [15:0] d_y [LAT];
    always @(posedge clk) begin
        d_x[0] <= sx;
        d_y[0] <= sy;
        for (int i = 1; i < LAT; i++) begin
            d_x[i] <= d_x[i-1];
            d_y[i] <= d_y[i-1];
        end
    end

    function automatic bit mask_fn(input int m, input int x, input int y);
        case (m)
            0:       return (x == y);
            1:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign is_within = mask_fn(mask_mode, int'(d_x[LAT-1]), int'(d_y[LAT-1]));

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  exp_ack[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, done or ack.
    always @(negedge clk) begin : monitor
        wr_t e;
        int  c;
        if (we) begin
            $display("write addr=%0d data=%h cycle=%0d", waddr, wdata, cyc);
            if (exp_wr.size() == 0) begin
                check("unexpected_write_addr", longint'(waddr), -1);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", longint'(waddr), e.addr);
                check("wr_data", longint'(wdata), e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
        if (done) begin
            if (exp_done.size() == 0) check("unexpected_done_cycle", cyc, -1);
            else begin
                c = exp_done.pop_front();
                check("done_cycle", cyc, c);
            end
        end
        if (clear_ack) begin
            if (exp_ack.size() == 0) check("unexpected_ack_cycle", cyc, -1);
            else begin
                c = exp_ack.pop_front();
                check("ack_cycle", cyc, c);
            end
        end
    end

    task automatic push_clear(input int base);
        wr_t e;
        for (int i = 0; i < W * H; i++) begin
            e.addr = i;
            e.data = 0;
            e.cyc  = base + 1 + i;
            exp_wr.push_back(e);
        end
        exp_ack.push_back(base + 1);
        exp_done.push_back(base + W * H);
    endtask

    task automatic push_tri(input int base, input int col, input int x0, input int x1,
                            input int y0, input int y1, input int m, input int limit,
                            input bit with_done);
        wr_t e;
        int  i;
        i = 0;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                if (mask_fn(m, x, y) && i < limit) begin
                    e.addr = y * W + x;
                    e.data = col;
                    e.cyc  = base + 1 + i + LAT;
                    exp_wr.push_back(e);
                end
                i++;
            end
        end
        if (with_done) exp_done.push_back(base + i + LAT);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_busy", busy, 0);
    endtask

    // Called at a negedge; holds tri_valid until the handshake cycle and returns it.
    task automatic send_tri(input logic [15:0] col, output int base);
        int n;
        n = 0;
        tri_valid = 1'b1;
        tri_col   = col;
        #1;
        while (!tri_ready && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("tri_accept_ready", tri_ready, 1);
        base = cyc;
        $display("triangle col=%h accepted at cycle %0d", col, base);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int base, base2, bad, cnt;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_we", we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack", clear_ack, 0);
        check("rst_ready", tri_ready, 0);
        check("rst_waddr", longint'(waddr), 0);
        check("rst_wdata", longint'(wdata), 0);
        check("rst_sx", longint'(sx), 0);
        check("rst_sy", longint'(sy), 0);
        rst_n = 1'b1;

        // 1: full-frame clear
        wait_idle();
        clear_req = 1'b1;
        base = cyc;
        $display("clear requested at cycle %0d", base);
        push_clear(base);
        @(negedge clk);
        clear_req = 1'b0;
        while (cyc < base + W * H) @(negedge clk);
        check("clear_busy_done_cycle", busy, 1);
        @(negedge clk);
        check("clear_busy_after", busy, 0);

        // 2: diagonal mask, 36 cycles valid-to-IDLE
        wait_idle();
        mask_mode = 0;
        send_tri(16'h0F00, base);
        push_tri(base, 16'h0F00, 0, W-1, 0, H-1, 0, 1 << 20, 1'b1);
        @(negedge clk);
        tri_valid = 1'b0;
        while (cyc < base + 35) @(negedge clk);
        #1;
        check("tri_busy_last", busy, 1);
        @(negedge clk);
        #1;
        check("tri_busy_idle", busy, 0);
        check("tri_ready_idle", tri_ready, 1);

        // 3: clear and triangle in the same cycle; clear wins
        wait_idle();
        clear_req = 1'b1;
        tri_valid = 1'b1;
        tri_col   = 16'h00F0;
        #1;
        check("collide_ready_low", tri_ready, 0);
        base = cyc;
        $display("clear+triangle collision at cycle %0d", base);
        push_clear(base);
        @(negedge clk);
        clear_req = 1'b0;
        bad = 0;
        while (cyc < base + W * H) begin
            #1;
            if (tri_ready) bad++;
            @(negedge clk);
        end
        #1;
        if (tri_ready) bad++;
        check("collide_ready_during_clear", bad, 0);
        @(negedge clk);
        send_tri(16'h00F0, base2);
        check("collide_tri_accept_cycle", base2, base + W * H + 1);
        push_tri(base2, 16'h00F0, 0, W-1, 0, H-1, 0, 1 << 20, 1'b1);
        @(negedge clk);
        tri_valid = 1'b0;

        // 6: tri_valid held across a pass; exactly one accept per handshake
        wait_idle();
        send_tri(16'h1111, base);
        push_tri(base, 16'h1111, 0, W-1, 0, H-1, 0, 1 << 20, 1'b1);
        @(negedge clk);
        tri_col = 16'h2222;
        bad = 0;
        while (cyc < base + W * H + LAT) begin
            #1;
            if (tri_ready) bad++;
            @(negedge clk);
        end
        check("held_ready_low", bad, 0);
        send_tri(16'h2222, base2);
        check("held_second_accept_cycle", base2, base + W * H + LAT + 1);
        push_tri(base2, 16'h2222, 0, W-1, 0, H-1, 0, 1 << 20, 1'b1);
        @(negedge clk);
        tri_valid = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        check("held_no_extra_pass", busy, 0);

        // 4: reset in the middle of a sweep
        mask_mode = 1;
        send_tri(16'hABCD, base);
        push_tri(base, 16'hABCD, 0, W-1, 0, H-1, 1, 7, 1'b0);
        @(negedge clk);
        tri_valid = 1'b0;
        while (cyc < base + 10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        $display("reset asserted mid-sweep at cycle %0d", cyc);
        #1;
        check("midrst_we", we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_waddr", longint'(waddr), 0);
        check("midrst_wdata", longint'(wdata), 0);
        check("midrst_sx", longint'(sx), 0);
        check("midrst_sy", longint'(sy), 0);
        check("midrst_ready", tri_ready, 0);
        check("midrst_writes_seen", exp_wr.size(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (we) cnt++;
        end
        check("postrst_no_we", cnt, 0);
        check("postrst_idle", busy, 0);

`ifdef SWEEP_BBOX_EN
        // 5: bounding box sweep and empty box
        wait_idle();
        mask_mode = 1;
        bbox_x0 = 16'd2; bbox_x1 = 16'd3; bbox_y0 = 16'd1; bbox_y1 = 16'd2;
        send_tri(16'h7777, base);
        push_tri(base, 16'h7777, 2, 3, 1, 2, 1, 1 << 20, 1'b1);
        @(negedge clk);
        tri_valid = 1'b0;
        wait_idle();
        bbox_x0 = 16'd5; bbox_x1 = 16'd4; bbox_y0 = 16'd0; bbox_y1 = 16'd3;
        send_tri(16'h5555, base);
        push_tri(base, 16'h5555, 5, 4, 0, 3, 1, 1 << 20, 1'b1);
        @(negedge clk);
        tri_valid = 1'b0;
        wait_idle();
        bbox_x0 = 16'd0; bbox_x1 = 16'd7; bbox_y0 = 16'd0; bbox_y1 = 16'd3;
`endif

        wait_idle();
        repeat (5) @(negedge clk);
        check("final_writes_pending", exp_wr.size(), 0);
        check("final_done_pending", exp_done.size(), 0);
        check("final_ack_pending", exp_ack.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
